// File: rtl/key_repeat_pkg.sv
// rtl/key_repeat_pkg.sv - shared types, default timing constants and counter sizing for key_repeat
package key_repeat_pkg;

    typedef enum logic [1:0] {
        RPT_IDLE,
        RPT_DELAY,
        RPT_REPEAT
    } repeat_state_t;

    typedef enum logic {
        DIR_LEFT,
        DIR_RIGHT
    } dir_t;

    // Defaults for a 100 MHz clock
    localparam int DEFAULT_DAS_CYCLES  = 16_000_000;
    localparam int DEFAULT_ARR_CYCLES  = 5_000_000;
    localparam int DEFAULT_SOFT_CYCLES = 3_000_000;

    // Bits needed to hold (max(a, b) - 1); never narrower than one bit
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/key_repeat_channel.sv
// rtl/key_repeat_channel.sv - one auto-repeat channel: first pulse, delay, then periodic repeat
module key_repeat_channel
    import key_repeat_pkg::*;
#(
    parameter int FIRST_CYCLES = DEFAULT_DAS_CYCLES,
    parameter int NEXT_CYCLES  = DEFAULT_ARR_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic held,
    input  logic press,
    input  logic inhibit,
    output logic pulse
);

    localparam int CW = cnt_width(FIRST_CYCLES, NEXT_CYCLES);
    localparam logic [CW-1:0] FIRST_LOAD = CW'(FIRST_CYCLES - 1);
    localparam logic [CW-1:0] NEXT_LOAD  = CW'(NEXT_CYCLES - 1);
    // A separate delay phase only exists when the first gap differs from the repeat gap
    localparam repeat_state_t PRESS_STATE =
        (FIRST_CYCLES == NEXT_CYCLES) ? RPT_REPEAT : RPT_DELAY;

    repeat_state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          pulse_n;

    // State, counter and registered pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RPT_IDLE;
            cnt   <= '0;
            pulse <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            pulse <= pulse_n;
        end
    end

    // Next state: disable wins, then inhibit freezes, then a press (re)starts the sequence
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        pulse_n = 1'b0;
        if (!enable) begin
            state_n = RPT_IDLE;
            cnt_n   = '0;
        end else if (inhibit) begin
            state_n = state;
            cnt_n   = cnt;
        end else if (press) begin
            pulse_n = 1'b1;
            cnt_n   = FIRST_LOAD;
            state_n = PRESS_STATE;
        end else begin
            case (state)
                RPT_DELAY, RPT_REPEAT: begin
                    if (!held) begin
                        state_n = RPT_IDLE;
                        cnt_n   = '0;
                    end else if (cnt == '0) begin
                        pulse_n = 1'b1;
                        cnt_n   = NEXT_LOAD;
                        state_n = RPT_REPEAT;
                    end else begin
                        cnt_n = cnt - CW'(1);
                    end
                end
                default: begin
                    state_n = RPT_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/key_repeat.sv
// rtl/key_repeat.sv - button levels to game_control key pulses with DAS/ARR and one-shots
module key_repeat
    import key_repeat_pkg::*;
#(
    parameter int DAS_CYCLES  = DEFAULT_DAS_CYCLES,
    parameter int ARR_CYCLES  = DEFAULT_ARR_CYCLES,
    parameter int SOFT_CYCLES = DEFAULT_SOFT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic btn_left,
    input  logic btn_right,
    input  logic btn_down,
    input  logic btn_rot_cw,
    input  logic btn_rot_ccw,
    input  logic btn_drop,
    input  logic btn_hold,
    output logic key_left,
    output logic key_right,
    output logic key_down,
    output logic key_rotate_cw,
    output logic key_rotate_ccw,
    output logic key_drop,
    output logic key_hold,
    output logic key_drop_held
);

    logic prev_left, prev_right, prev_down;
    logic prev_rot_cw, prev_rot_ccw, prev_drop, prev_hold;
    dir_t last_dir, dir_n;
    logic restart_left, restart_right;
    logic inhibit_left, inhibit_right;

    logic press_left, press_right, press_down;
    logic press_rot_cw, press_rot_ccw, press_drop, press_hold;

    assign press_left    = btn_left    & ~prev_left;
    assign press_right   = btn_right   & ~prev_right;
    assign press_down    = btn_down    & ~prev_down;
    assign press_rot_cw  = btn_rot_cw  & ~prev_rot_cw;
    assign press_rot_ccw = btn_rot_ccw & ~prev_rot_ccw;
    assign press_drop    = btn_drop    & ~prev_drop;
    assign press_hold    = btn_hold    & ~prev_hold;

    // Previous levels track the buttons in reset too, so a key held through reset is not a press
    always_ff @(posedge clk) begin
        prev_left    <= btn_left;
        prev_right   <= btn_right;
        prev_down    <= btn_down;
        prev_rot_cw  <= btn_rot_cw;
        prev_rot_ccw <= btn_rot_ccw;
        prev_drop    <= btn_drop;
        prev_hold    <= btn_hold;
    end

    // Direction arbitration: newest press wins, left beats right on a tie, and releasing the
    // active direction hands control back to a still-held opposite key as a fresh press
    always_comb begin
        restart_left  = btn_left  & ~btn_right & prev_right & (last_dir == DIR_RIGHT);
        restart_right = btn_right & ~btn_left  & prev_left  & (last_dir == DIR_LEFT);
        dir_n = last_dir;
        if (press_left)
            dir_n = DIR_LEFT;
        else if (press_right)
            dir_n = DIR_RIGHT;
        else if (restart_left)
            dir_n = DIR_LEFT;
        else if (restart_right)
            dir_n = DIR_RIGHT;
        inhibit_left  = btn_left & btn_right & (dir_n == DIR_RIGHT);
        inhibit_right = btn_left & btn_right & (dir_n == DIR_LEFT);
    end

    // Last active direction register
    always_ff @(posedge clk) begin
        if (rst)
            last_dir <= DIR_LEFT;
        else
            last_dir <= dir_n;
    end

    // One-shot pulses and the drop-held level
    always_ff @(posedge clk) begin
        if (rst) begin
            key_rotate_cw  <= 1'b0;
            key_rotate_ccw <= 1'b0;
            key_drop       <= 1'b0;
            key_hold       <= 1'b0;
            key_drop_held  <= 1'b0;
        end else begin
            key_rotate_cw  <= press_rot_cw  & enable;
            key_rotate_ccw <= press_rot_ccw & enable;
            key_drop       <= press_drop    & enable;
            key_hold       <= press_hold    & enable;
            key_drop_held  <= btn_drop      & enable;
        end
    end

    key_repeat_channel #(
        .FIRST_CYCLES (DAS_CYCLES),
        .NEXT_CYCLES  (ARR_CYCLES)
    ) u_left (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .held    (btn_left),
        .press   (press_left | restart_left),
        .inhibit (inhibit_left),
        .pulse   (key_left)
    );

    key_repeat_channel #(
        .FIRST_CYCLES (DAS_CYCLES),
        .NEXT_CYCLES  (ARR_CYCLES)
    ) u_right (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .held    (btn_right),
        .press   (press_right | restart_right),
        .inhibit (inhibit_right),
        .pulse   (key_right)
    );

    key_repeat_channel #(
        .FIRST_CYCLES (SOFT_CYCLES),
        .NEXT_CYCLES  (SOFT_CYCLES)
    ) u_down (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .held    (btn_down),
        .press   (press_down),
        .inhibit (1'b0),
        .pulse   (key_down)
    );

endmodule

// File: tb/tb_key_repeat.sv
// tb/tb_key_repeat.sv - directed table and sequence bench for key_repeat
module tb_key_repeat;

    // button bit order: {left, right, down, rot_cw, rot_ccw, drop, hold}
    localparam logic [6:0] B_L   = 7'b1000000;
    localparam logic [6:0] B_R   = 7'b0100000;
    localparam logic [6:0] B_D   = 7'b0010000;
    localparam logic [6:0] B_CW  = 7'b0001000;
    localparam logic [6:0] B_CCW = 7'b0000100;
    localparam logic [6:0] B_DR  = 7'b0000010;
    localparam logic [6:0] B_H   = 7'b0000001;
    // output bit order: {left, right, down, rot_cw, rot_ccw, drop, hold, drop_held}
    localparam logic [7:0] O_L   = 8'h80;
    localparam logic [7:0] O_R   = 8'h40;
    localparam logic [7:0] O_D   = 8'h20;
    localparam logic [7:0] O_CW  = 8'h10;
    localparam logic [7:0] O_DR  = 8'h04;
    localparam logic [7:0] O_H   = 8'h02;
    localparam logic [7:0] O_HLD = 8'h01;

    typedef struct {
        logic       rst;
        logic       en;
        logic [6:0] btn;
        logic [7:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst, enable;
    logic btn_left, btn_right, btn_down, btn_rot_cw, btn_rot_ccw, btn_drop, btn_hold;
    logic key_left, key_right, key_down, key_rotate_cw, key_rotate_ccw, key_drop, key_hold;
    logic key_drop_held;

    int n_cmp = 0;
    int n_bad = 0;
    int step_no = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    key_repeat #(
        .DAS_CYCLES  (4),
        .ARR_CYCLES  (2),
        .SOFT_CYCLES (3)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .btn_left       (btn_left),
        .btn_right      (btn_right),
        .btn_down       (btn_down),
        .btn_rot_cw     (btn_rot_cw),
        .btn_rot_ccw    (btn_rot_ccw),
        .btn_drop       (btn_drop),
        .btn_hold       (btn_hold),
        .key_left       (key_left),
        .key_right      (key_right),
        .key_down       (key_down),
        .key_rotate_cw  (key_rotate_cw),
        .key_rotate_ccw (key_rotate_ccw),
        .key_drop       (key_drop),
        .key_hold       (key_hold),
        .key_drop_held  (key_drop_held)
    );

    task automatic add(input logic r, input logic e, input logic [6:0] b, input logic [7:0] x);
        vec_t v;
        v.rst = r; v.en = e; v.btn = b; v.exp = x;
        vecs.push_back(v);
    endtask

    // Drive one cycle of inputs, clock it, then compare outputs mid-cycle
    task automatic cyc(input logic r, input logic e, input logic [6:0] b,
                       input logic [7:0] x, input string tag);
        logic [7:0] act;
        rst = r;
        enable = e;
        {btn_left, btn_right, btn_down, btn_rot_cw, btn_rot_ccw, btn_drop, btn_hold} = b;
        @(posedge clk);
        @(negedge clk);
        act = {key_left, key_right, key_down, key_rotate_cw, key_rotate_ccw,
               key_drop, key_hold, key_drop_held};
        n_cmp++;
        if (act !== x) begin
            n_bad++;
            $display("FAIL %s step %0d: outputs got %b expected %b", tag, step_no, act, x);
        end
        step_no++;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b1;
        {btn_left, btn_right, btn_down, btn_rot_cw, btn_rot_ccw, btn_drop, btn_hold} = '0;

        // reset state
        add(1, 1, 0, 0);
        add(1, 1, 0, 0);
        add(0, 1, 0, 0);
        // rotate tap held 5 cycles
        for (int j = 0; j < 5; j++) add(0, 1, B_CW, (j == 0) ? O_CW : 8'h00);
        add(0, 1, 0, 0);
        // left held 12 cycles: DAS 4 then ARR 2
        for (int j = 0; j < 12; j++)
            add(0, 1, B_L, (j == 0 || j == 4 || j == 6 || j == 8 || j == 10) ? O_L : 8'h00);
        for (int j = 0; j < 3; j++) add(0, 1, 0, 0);
        // down held 10 cycles: every 3
        for (int j = 0; j < 10; j++)
            add(0, 1, B_D, (j == 0 || j == 3 || j == 6 || j == 9) ? O_D : 8'h00);
        add(0, 1, 0, 0);
        // drop held 4 cycles
        for (int j = 0; j < 4; j++) add(0, 1, B_DR, (j == 0) ? (O_DR | O_HLD) : O_HLD);
        add(0, 1, 0, 0);
        // release then immediate re-press
        for (int j = 0; j < 3; j++) add(0, 1, B_L, (j == 0) ? O_L : 8'h00);
        add(0, 1, 0, 0);
        add(0, 1, B_L, O_L);
        add(0, 1, B_L, 0);
        add(0, 1, 0, 0);
        // simultaneous left+right: left wins; left release hands over to right
        for (int j = 0; j < 5; j++) add(0, 1, B_L | B_R, (j == 0 || j == 4) ? O_L : 8'h00);
        add(0, 1, B_R, O_R);
        add(0, 1, B_R, 0);
        add(0, 1, 0, 0);
        // independent pulses coincide
        add(0, 1, B_D | B_CW, O_D | O_CW);
        add(0, 1, 0, 0);

        foreach (vecs[i]) cyc(vecs[i].rst, vecs[i].en, vecs[i].btn, vecs[i].exp, "table");

        // left held, right pressed at offset 3 and released at offset 8
        for (int j = 0; j < 15; j++) begin
            logic [6:0] b;
            logic [7:0] x;
            b = (j >= 3 && j <= 7) ? (B_L | B_R) : ((j == 14) ? 7'h00 : B_L);
            x = 8'h00;
            if (j == 0 || j == 8 || j == 12) x = O_L;
            if (j == 3 || j == 7) x = O_R;
            cyc(0, 1, b, x, "arbitration");
        end

        // hold key through reset: no pulse until released and re-pressed
        cyc(1, 1, B_H, 0, "hold_rst");
        cyc(1, 1, B_H, 0, "hold_rst");
        for (int j = 0; j < 3; j++) cyc(0, 1, B_H, 0, "hold_after_rst");
        cyc(0, 1, 0, 0, "hold_release");
        for (int j = 0; j < 3; j++) cyc(0, 1, B_H, (j == 0) ? O_H : 8'h00, "hold_repress");
        cyc(0, 1, 0, 0, "hold_release");

        // reset in the middle of a repeat
        cyc(0, 1, B_L, O_L, "rst_mid");
        cyc(1, 1, B_L, 0, "rst_mid");
        cyc(1, 1, B_L, 0, "rst_mid");
        for (int j = 0; j < 6; j++) cyc(0, 1, B_L, 0, "rst_mid_after");
        cyc(0, 1, 0, 0, "rst_mid_release");

        // enable low suppresses everything
        cyc(0, 0, B_L | B_D | B_CW, 0, "disabled");
        cyc(0, 0, 0, 0, "disabled");
        cyc(0, 0, B_R | B_CCW | B_DR | B_H, 0, "disabled");
        cyc(0, 0, 7'h7f, 0, "disabled");
        cyc(0, 0, 0, 0, "disabled");
        cyc(0, 0, B_L, 0, "disabled");
        for (int j = 0; j < 6; j++) cyc(0, 1, B_L, 0, "enable_rise_held");
        cyc(0, 1, 0, 0, "enable_release");
        cyc(0, 1, B_L, O_L, "enable_repress");
        cyc(0, 1, 0, 0, "enable_release");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
